// File: rtl/example_drv.sv
// example_drv: prefetching valid/ready stimulus driver fed by a record generator.
// Macros: EXAMPLE_DRV_FINAL_REPORT_EN (end-of-run summary).

package example_drv_pkg;
  // SV stand-in for the C generator so the driver builds without a C library.
  typedef struct {
    int data;
    int gap;
    bit last;
  } stub_rec_t;

  stub_rec_t   stub_q[$];
  int unsigned call_count;
  int unsigned last_cycle;
  int unsigned summary_beats;
  bit          summary_exhausted;

  function automatic int c_driver_next(input int unsigned cycle, output int data,
                                       output int gap, output bit last);
    stub_rec_t r;
    call_count++;
    last_cycle = cycle;
    if (stub_q.size() == 0) begin
      data = 0;
      gap  = 0;
      last = 1'b0;
      return 0;
    end
    r    = stub_q.pop_front();
    data = r.data;
    gap  = r.gap;
    last = r.last;
    return 1;
  endfunction

  function automatic void c_driver_summary(input int unsigned beats, input bit exhausted);
    summary_beats     = beats;
    summary_exhausted = exhausted;
  endfunction
endpackage

module example_drv #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned GAP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [31:0]       cycle_count,
  output logic              drv_valid,
  output logic [DATA_W-1:0] drv_data,
  output logic              drv_last,
  input  logic              drv_ready,
  output logic              done,
  output logic [31:0]       xfer_count
);
  import example_drv_pkg::*;

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GAP   = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic              ok;
    logic              last;
    logic [GAP_W-1:0]  gap;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     count_q, count_d, occ;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_slot;
  logic              called_q, exhausted_q, exh, pend_ok, fetch_en, pop;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [31:0]       xfer_q, xfer_d;

  function automatic entry_t fetch_rec(input logic [31:0] cyc);
    int     d;
    int     g;
    bit     l;
    int     rv;
    entry_t e;
    rv     = c_driver_next(cyc, d, g, l);
    e.ok   = (rv != 0);
    e.last = l;
    e.gap  = g[GAP_W-1:0];
    e.data = d[DATA_W-1:0];
    return e;
  endfunction

  // A call's result lands in the slot at wr_ptr_q; it is committed (or marks exhaustion)
  // one edge later but already counts as occupancy in the cycle after the call.
  always_comb begin
    pend_ok  = called_q & mem[wr_ptr_q].ok;
    exh      = exhausted_q | (called_q & ~mem[wr_ptr_q].ok);
    occ      = count_q + CW'(pend_ok);
    wr_slot  = wr_ptr_q + PW'(pend_ok);
    fetch_en = enable & ~exh & (occ < FULL);
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    data_d  = data_q;
    last_d  = last_q;
    xfer_d  = xfer_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && occ != '0) begin
          pop = 1'b1;
        end else if (exh && occ == '0) begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (enable) begin
          if (gap_q == GAP_W'(1)) state_d = DRIVE;
          else gap_d = gap_q - GAP_W'(1);
        end
      end
      DRIVE: begin
        if (drv_ready) begin
          xfer_d = xfer_q + 32'd1;
          if (enable && occ != '0) pop = 1'b1;
          else state_d = IDLE;
        end
      end
      default: ;
    endcase
    if (pop) begin
      data_d  = mem[rd_ptr_q].data;
      last_d  = mem[rd_ptr_q].last;
      gap_d   = mem[rd_ptr_q].gap;
      state_d = (mem[rd_ptr_q].gap != '0) ? GAP : DRIVE;
    end
  end

  always_comb begin
    count_d  = occ - CW'(pop);
    wr_ptr_d = wr_slot;
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      called_q    <= 1'b0;
      exhausted_q <= 1'b0;
      gap_q       <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      xfer_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      called_q    <= fetch_en;
      exhausted_q <= exh;
      gap_q       <= gap_d;
      data_q      <= data_d;
      last_q      <= last_d;
      xfer_q      <= xfer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fetch_en) mem[wr_slot] <= fetch_rec(cycle_count);
  end

  assign drv_valid  = (state_q == DRIVE);
  assign drv_data   = data_q;
  assign drv_last   = last_q;
  assign done       = (state_q == DONE);
  assign xfer_count = xfer_q;

`ifdef EXAMPLE_DRV_FINAL_REPORT_EN
  final begin
    c_driver_summary(xfer_q, exhausted_q);
    $display("%m: %0d beats, done=%0d", xfer_q, done);
  end
`endif

endmodule

// File: doc/example_drv.md
Name: example_drv

Overview:
- SV-side stimulus driver: pulls transaction records from a C-side generator via DPI-C import calls and drives them into the DUT over a valid/ready handshake.
- Traffic direction is C -> DUT, the opposite of the C-monitor collector path.
- Records are prefetched into a small FIFO so C-call latency never stalls the handshake.
- Instantiated by bind into hello_world, alongside the collector interface.

Parameters:
- DATA_W, 32, width of drv_data; must be 1..32.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- GAP_W, 8, width of per-record idle-gap field; max gap 2**GAP_W-1 cycles.

Ports:
- clk  input  1  design clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  fetch/drive enable; 0 freezes fetch and gap counting but holds any presented beat.
- cycle_count  input  32  timestamp passed to each C call.
- drv_valid  output  1  beat valid.
- drv_data  output  DATA_W  beat payload.
- drv_last  output  1  last beat of packet.
- drv_ready  input  1  DUT accepts beat.
- done  output  1  generator exhausted and all beats delivered.
- xfer_count  output  32  accepted-beat counter.

Behaviour:
- DPI import: function int c_driver_next(input int unsigned cycle, output int data, output int gap, output bit last).
  - Returns 1 when a record is produced, 0 when the generator is exhausted.
  - gap is truncated to GAP_W bits; data is truncated to DATA_W bits.
- Reset values: drv_valid=0, drv_data=0, drv_last=0, done=0, xfer_count=0, FIFO empty, exhausted flag=0, FSM=IDLE.
- Fetch side:
  - At most one call per cycle, made on posedge when !rst && enable && !exhausted && fifo_count<DEPTH.
  - Return 1: push {data,gap,last}, visible to the drive side next cycle.
  - Return 0: set sticky exhausted; no further calls until reset.
- FSM states and transitions:
  - IDLE: if FIFO non-empty and enable: pop head into holding regs; go to GAP if gap>0 (load gap counter = gap), else DRIVE.
  - GAP: counter decrements each enabled cycle; at 1, go to DRIVE. A gap of N yields exactly N idle cycles between pop and drv_valid.
  - DRIVE: drv_valid=1 with data/last from holding regs.
    - On drv_valid&&drv_ready: xfer_count += 1 (wraps at 2**32).
    - Back-to-back: if FIFO non-empty, pop the next record in the same cycle; with gap=0 it stays in DRIVE with drv_valid continuously high (full throughput). Otherwise go to IDLE.
  - DONE: entered from IDLE when exhausted && FIFO empty. done=1, sticky until reset.
- Handshake rules:
  - drv_data/drv_last stable while drv_valid && !drv_ready.
  - drv_valid never drops without acceptance; enable=0 does not drop it.
  - drv_data/drv_last are don't-care (held) when drv_valid=0.
- Simultaneous push and pop in one cycle: fifo_count unchanged; full and empty are both legal at the boundary.
  - A push when full is impossible by construction; the fetch gate prevents it.
- Exhaustion during a pending beat: done asserts only after that beat is accepted and the FIFO drains.
- Reset mid-operation: FIFO flushed, pending beat dropped, outputs return to reset values asynchronously. Records already fetched are lost; the C generator is not rewound.
- The first fetch occurs on the first posedge with rst=0.

Optional Feature:
- EXAMPLE_DRV_FINAL_REPORT_EN.
- Defined: a final block calls DPI import c_driver_summary(input int unsigned beats, input bit exhausted) and $displays "%m: <xfer_count> beats, done=<done>".
- Undefined: no final block, no summary import; functional behaviour is identical.

Test Plan:
- C stub returns 3 records {0xA,gap0,last0},{0xB,gap0,last0},{0xC,gap0,last1} then 0; ready tied 1 -> drv_valid high 3 consecutive cycles with data A,B,C; last only on C; xfer_count=3; done=1 one cycle after C accepted.
- Single record gap=5 -> exactly 5 cycles of drv_valid=0 between pop and drv_valid=1.
- drv_ready held 0 for 10 cycles during beat 0x55 -> data/last stable for all 10 cycles; FIFO fills to DEPTH=4 and no further C calls occur; drains in order once ready=1.
- enable dropped mid-gap (gap=4, after 2 cycles) for 3 cycles -> counter frozen; valid appears 2 enabled cycles after enable returns; no C calls while enable=0.
- Stub returns 0 on first call -> no valid ever; done=1 after 2 cycles; xfer_count=0.
- rst pulsed while DRIVE with ready=0 -> drv_valid=0 immediately (async); FIFO empty, xfer_count=0, done=0; fetching resumes on the first posedge after release.
